upload_packet_arbiter: RTL and testbench



---
 rtl/upload_packet_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_upload_packet_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/upload_packet_arbiter.sv
// Merges the command-response (A) and digital-capture (B) upload byte streams into
// one framed stream: AA 55 SRC LEN payload CSUM, packets served round-robin.

module upload_packet_arbiter_fifo #(
  parameter int DEPTH       = 256,
  parameter int MAX_PAYLOAD = 64,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             wr_data,
  input  logic                   wr_valid,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             head,
  output logic [7:0]             head_after_pop,
  output logic                   afull,
  output logic                   overflow,
  output logic                   src_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - 8);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_PAYLOAD);
  localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic [CW-1:0] count_next;
  logic          wr_en;

  // A byte arriving while full is dropped even if a pop frees a slot that cycle.
  assign wr_en = wr_valid && (count != FULL_C);

  always_comb begin
    count_next = count;
    if (wr_en && !pop)      count_next = count + CW'(1);
    else if (!wr_en && pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      afull    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      afull <= (count_next >= AFULL_C);
      if (wr_valid && !wr_en) overflow <= 1'b1;
      if (wr_en)                                timer <= '0;
      else if ((count != '0) && (timer != TMO_C)) timer <= timer + TW'(1);
    end
  end

  assign head           = mem[rd_ptr];
  assign head_after_pop = mem[rd_ptr + AW'(1)];
  assign src_ready      = (count >= MAX_C) || ((count != '0) && (timer == TMO_C));
endmodule

module upload_packet_arbiter #(
  parameter int FIFO_DEPTH  = 256,
  parameter int MAX_PAYLOAD = 64,
  parameter int TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_afull,
  output logic       a_overflow,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_afull,
  output logic       b_overflow,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] state_dbg
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Output handshake: a byte moves when out_valid && out_ready on a rising edge; once
  // out_valid is high, out_data/out_valid hold until that transfer happens.
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, SRC_S, LEN_S, PAYLOAD, CSUM} state_t;

  state_t        state, state_next;
  logic [CW-1:0] a_count, b_count, grant_count;
  logic [7:0]    a_head, a_head_nx, b_head, b_head_nx;
  logic          a_ready, b_ready, grant_a, grant_b, pop_a, pop_b;
  logic          xfer, sel_b, last_b, valid_next;
  logic [7:0]    len, left, acc, acc_next, data_next, pay_next, grant_len;

  upload_packet_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .MAX_PAYLOAD(MAX_PAYLOAD), .TIMEOUT(TIMEOUT)) u_fifo_a (
    .clk(clk), .rst(rst), .wr_data(a_data), .wr_valid(a_valid), .pop(pop_a),
    .count(a_count), .head(a_head), .head_after_pop(a_head_nx),
    .afull(a_afull), .overflow(a_overflow), .src_ready(a_ready)
  );

  upload_packet_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .MAX_PAYLOAD(MAX_PAYLOAD), .TIMEOUT(TIMEOUT)) u_fifo_b (
    .clk(clk), .rst(rst), .wr_data(b_data), .wr_valid(b_valid), .pop(pop_b),
    .count(b_count), .head(b_head), .head_after_pop(b_head_nx),
    .afull(b_afull), .overflow(b_overflow), .src_ready(b_ready)
  );

  assign xfer    = out_valid && out_ready;
  assign grant_a = (state == IDLE) && a_ready && (!b_ready || last_b);
  assign grant_b = (state == IDLE) && b_ready && !grant_a;
  assign pop_a   = xfer && (state == PAYLOAD) && !sel_b;
  assign pop_b   = xfer && (state == PAYLOAD) && sel_b;

  assign grant_count = grant_b ? b_count : a_count;
  assign grant_len   = (grant_count >= CW'(MAX_PAYLOAD)) ? 8'(MAX_PAYLOAD) : 8'(grant_count);
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_a || grant_b)      state_next = HDR0;
      HDR0:    if (xfer)                    state_next = HDR1;
      HDR1:    if (xfer)                    state_next = SRC_S;
      SRC_S:   if (xfer)                    state_next = LEN_S;
      LEN_S:   if (xfer)                    state_next = PAYLOAD;
      PAYLOAD: if (xfer && (left == 8'd1))  state_next = CSUM;
      CSUM:    if (xfer)                    state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // Output bytes are computed for the state being entered so they leave a flop.
  always_comb begin
    acc_next = acc;
    if (state == IDLE)
      acc_next = 8'h00;
    else if (xfer && ((state == SRC_S) || (state == LEN_S) || (state == PAYLOAD)))
      acc_next = acc + out_data;
    if (sel_b) pay_next = pop_b ? b_head_nx : b_head;
    else       pay_next = pop_a ? a_head_nx : a_head;
    valid_next = (state_next != IDLE);
    data_next  = 8'h00;
    unique case (state_next)
      IDLE:    data_next = 8'h00;
      HDR0:    data_next = 8'hAA;
      HDR1:    data_next = 8'h55;
      SRC_S:   data_next = sel_b ? 8'h02 : 8'h01;
      LEN_S:   data_next = len;
      PAYLOAD: data_next = pay_next;
      CSUM:    data_next = acc_next;
      default: data_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      acc       <= 8'h00;
      sel_b     <= 1'b0;
      last_b    <= 1'b1;
      len       <= 8'h00;
      left      <= 8'h00;
    end else begin
      out_valid <= valid_next;
      out_data  <= data_next;
      acc       <= acc_next;
      if (grant_a || grant_b) begin
        sel_b  <= grant_b;
        last_b <= grant_b;
        len    <= grant_len;
        left   <= grant_len;
      end else if (pop_a || pop_b) begin
        left <= left - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_upload_packet_arbiter.sv
// Directed bench for upload_packet_arbiter: framing, latency, timeout flush,
// round-robin, backpressure, overflow and mid-packet reset.

module tb_upload_packet_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data, out_data;
  logic       a_valid, b_valid, out_ready, out_valid;
  logic       a_afull, a_overflow, b_afull, b_overflow;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pay_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  upload_packet_arbiter dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_afull(a_afull), .a_overflow(a_overflow),
    .b_data(b_data), .b_valid(b_valid), .b_afull(b_afull), .b_overflow(b_overflow),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Builds the expected frame for the bytes in pay_q.
  task automatic push_pkt(input logic [7:0] src);
    logic [7:0] sum;
    sum = src + 8'(pay_q.size());
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(src);
    exp_q.push_back(8'(pay_q.size()));
    for (int i = 0; i < pay_q.size(); i++) begin
      exp_q.push_back(pay_q[i]);
      sum = sum + pay_q[i];
    end
    exp_q.push_back(sum);
    pay_q.delete();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= exp_q.size()) break;
      step();
    end
    repeat (4) step();
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  // Output capture plus hold-while-stalled checking.
  always @(posedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'h0, out_valid}, 32'h1);
        check("stall_data", {24'h0, out_data}, {24'h0, prev_data});
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a_data = 8'h00; a_valid = 1'b0; b_data = 8'h00; b_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_a_afull", {31'h0, a_afull}, 32'h0);
    check("rst_b_afull", {31'h0, b_afull}, 32'h0);
    check("rst_a_ovf", {31'h0, a_overflow}, 32'h0);
    check("rst_b_ovf", {31'h0, b_overflow}, 32'h0);
    check("rst_state", {29'h0, state_dbg}, 32'h0);

    // Full 64-byte packet on A, start latency, throughput and inter-packet bubble.
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      a_data = 8'(i); a_valid = 1'b1; step();
    end
    a_valid = 1'b0;
    check("start_lat_early", {31'h0, out_valid}, 32'h0);
    step();
    check("start_lat_valid", {31'h0, out_valid}, 32'h1);
    check("start_lat_aa", {24'h0, out_data}, 32'hAA);
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i));
    push_pkt(8'h01);
    repeat (69) step();
    check("burst_count", 32'(got_q.size()), 32'd69);
    check("gap_bubble", {31'h0, out_valid}, 32'h0);
    compare_stream("pkt_a_full");

    // Timeout flush of a 3-byte B packet.
    for (int i = 0; i < 3; i++) begin
      b_data = 8'(16 * (i + 1)); b_valid = 1'b1; step();
    end
    b_valid = 1'b0;
    repeat (1024) step();
    check("tmo_early", {31'h0, out_valid}, 32'h0);
    step();
    check("tmo_valid", {31'h0, out_valid}, 32'h1);
    check("tmo_aa", {24'h0, out_data}, 32'hAA);
    pay_q.push_back(8'h10); pay_q.push_back(8'h20); pay_q.push_back(8'h30);
    push_pkt(8'h02);
    drain(50);
    compare_stream("tmo_pkt");

    // Round robin: simultaneous ties, A wins both since B was served last.
    for (int i = 0; i < 64; i++) begin
      a_data = 8'(128 + i); b_data = 8'(255 - i); a_valid = 1'b1; b_valid = 1'b1; step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(128 + i));
    push_pkt(8'h01);
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(255 - i));
    push_pkt(8'h02);
    drain(400);
    compare_stream("rr_first");
    for (int i = 0; i < 64; i++) begin
      a_data = 8'(3 * i); b_data = 8'(i) ^ 8'h5A; a_valid = 1'b1; b_valid = 1'b1; step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(3 * i));
    push_pkt(8'h01);
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i) ^ 8'h5A);
    push_pkt(8'h02);
    drain(400);
    compare_stream("rr_second");

    // Backpressure: pseudo-random out_ready across a 64-byte A packet.
    for (int i = 0; i < 64; i++) begin
      a_data = 8'(i); a_valid = 1'b1; out_ready = 1'($urandom_range(0, 1)); step();
    end
    a_valid = 1'b0;
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i));
    push_pkt(8'h01);
    for (int i = 0; i < 2000; i++) begin
      if (got_q.size() >= exp_q.size()) break;
      out_ready = 1'($urandom_range(0, 1)); step();
    end
    out_ready = 1'b1;
    repeat (4) step();
    compare_stream("bp_pkt");

    // Overflow: FIFO_DEPTH+5 writes to A with the sink stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 261; i++) begin
      a_data = 8'(i); a_valid = 1'b1; step();
      if (i == 246) check("afull_247", {31'h0, a_afull}, 32'h0);
      if (i == 247) check("afull_248", {31'h0, a_afull}, 32'h1);
      if (i == 255) check("ovf_at_full", {31'h0, a_overflow}, 32'h0);
      if (i == 256) check("ovf_first_drop", {31'h0, a_overflow}, 32'h1);
    end
    a_valid = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 64; i++) pay_q.push_back(8'(p * 64 + i));
      push_pkt(8'h01);
    end
    out_ready = 1'b1;
    drain(400);
    compare_stream("ovf_drain");
    check("ovf_afull_clear", {31'h0, a_afull}, 32'h0);
    check("ovf_sticky", {31'h0, a_overflow}, 32'h1);
    check("ovf_b_clean", {31'h0, b_overflow}, 32'h0);

    // Reset in the middle of an A payload.
    for (int i = 0; i < 64; i++) begin
      a_data = 8'(i + 7); a_valid = 1'b1; step();
    end
    a_valid = 1'b0;
    repeat (9) step();
    check("mid_state_payload", {29'h0, state_dbg}, 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_data", {24'h0, out_data}, 32'h0);
    check("mid_rst_a_ovf", {31'h0, a_overflow}, 32'h0);
    check("mid_rst_a_afull", {31'h0, a_afull}, 32'h0);
    check("mid_rst_state", {29'h0, state_dbg}, 32'h0);
    step();
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    step();
    for (int i = 0; i < 3; i++) begin
      b_data = 8'(i + 1); b_valid = 1'b1; step();
    end
    b_valid = 1'b0;
    pay_q.push_back(8'h01); pay_q.push_back(8'h02); pay_q.push_back(8'h03);
    push_pkt(8'h02);
    drain(1100);
    compare_stream("post_rst_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
